// File: rtl/loop_cnt_nd.sv
// loop_cnt_nd: chained nested-loop counter with start/busy/done handshake.
// Level 0 is innermost; each level rolls over at its latched end number.
module loop_cnt_nd #(
    parameter int NUM_LEVELS         = 3,
    parameter int BITS_OF_END_NUMBER = 16,
    parameter int ITER_BITS          = NUM_LEVELS * BITS_OF_END_NUMBER
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 enable,
    input  logic                                 clear,
    input  logic                                 mode,
    input  logic [NUM_LEVELS*BITS_OF_END_NUMBER-1:0] final_numbers,
    output logic [NUM_LEVELS*BITS_OF_END_NUMBER-1:0] cnt_q,
    output logic [NUM_LEVELS-1:0]                level_last,
    output logic [ITER_BITS-1:0]                 iter_q,
    output logic                                 busy,
    output logic                                 done
);

    localparam int NL = NUM_LEVELS;
    localparam int W  = BITS_OF_END_NUMBER;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]           r_state;
    logic                 r_mode;
    logic                 r_done;
    logic [NL*W-1:0]      r_fin;
    logic [NL*W-1:0]      r_cnt;
    logic [ITER_BITS-1:0] r_iter;

    logic [W-1:0]         w_end [NL];
    logic [NL-1:0]        w_last;
    logic [NL-1:0]        w_carry;
    logic [NL*W-1:0]      w_cnt_nxt;
    logic [ITER_BITS-1:0] w_total;
    logic                 w_step;
    logic                 w_sweep_end;

    assign w_step      = (r_state == S_RUN) & enable & ~clear;
    assign w_sweep_end = w_step & (&w_last);

    genvar k;
    generate
        for (k = 0; k < NL; k++) begin : g_lvl
            logic [W-1:0] w_fin_k;
            logic [W-1:0] w_cnt_k;

            assign w_fin_k  = r_fin[k*W +: W];
            assign w_cnt_k  = r_cnt[k*W +: W];
            // A zero end number behaves as a single-value loop.
            assign w_end[k] = (w_fin_k == '0) ? W'(1) : w_fin_k;
            assign w_last[k] = (w_cnt_k == w_end[k] - W'(1));

            if (k == 0) begin : g_c0
                assign w_carry[k] = w_step;
            end else begin : g_cn
                assign w_carry[k] = w_step & (&w_last[k-1:0]);
            end

            assign w_cnt_nxt[k*W +: W] =
                !w_carry[k] ? w_cnt_k :
                w_last[k]   ? '0      :
                              w_cnt_k + W'(1);
        end
    endgenerate

    always_comb begin
        w_total = ITER_BITS'(1);
        for (int i = 0; i < NL; i++) begin
            w_total = w_total * ITER_BITS'(w_end[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
            r_fin   <= '0;
            r_cnt   <= '0;
            r_iter  <= '0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_iter  <= '0;
            end else if (r_state == S_IDLE) begin
                if (start) begin
                    r_fin   <= final_numbers;
                    r_mode  <= mode;
                    r_cnt   <= '0;
                    r_iter  <= '0;
                    r_state <= S_RUN;
                end
            end else if (w_step) begin
                if (w_sweep_end) begin
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                    if (r_mode) begin
                        r_iter <= '0;
                    end else begin
                        r_iter  <= w_total;
                        r_state <= S_IDLE;
                    end
                end else begin
                    r_cnt  <= w_cnt_nxt;
                    r_iter <= r_iter + ITER_BITS'(1);
                end
            end
        end
    end

    assign cnt_q      = r_cnt;
    assign level_last = w_last;
    assign iter_q     = r_iter;
    assign busy       = (r_state == S_RUN);
    assign done       = r_done;

endmodule
